// File: rtl/pool_stream_engine_pkg.sv
// Shared types for the pool stream engine: run mode, FSM states and a
// power-of-two helper used to decide whether average mode is legal.
package pool_pkg;

  typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_e;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pool_state_e;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/pool_stream_engine_if.sv
// Window-element input stream and pooled-vector output stream.
// master = producer/consumer side, slave = the engine.
interface pool_stream_engine_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 64
);
  logic                             in_valid;
  logic                             in_ready;
  logic [LANES-1:0][DATA_W-1:0]     in_data;
  logic                             in_last;
  logic                             out_valid;
  logic                             out_ready;
  logic [LANES-1:0][DATA_W-1:0]     out_data;
  logic                             out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pool_stream_engine_lane_alu.sv
// One pooling lane: accumulator, max/add reduction, mean shift and the
// out_data register. POOL_RELU_EN clamps negative lane results to zero.
module pool_lane_alu
  import pool_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int WIN_ELEMS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     beat,
  input  logic                     first,
  input  logic                     close,
  input  pool_mode_e               mode,
  input  logic signed [DATA_W-1:0] din,
  output logic        [DATA_W-1:0] res
);
  localparam int SH    = $clog2(WIN_ELEMS);
  localparam int ACC_W = DATA_W + SH;

  logic signed [ACC_W-1:0]  acc, din_x, nxt, avg_sh;
  logic signed [DATA_W-1:0] red;

  always_comb begin
    din_x = ACC_W'(din);
    if (first)                nxt = din_x;
    else if (mode == POOL_AVG) nxt = acc + din_x;
    else                      nxt = (din_x > acc) ? din_x : acc;
    // floor division by the window size; the mean always fits DATA_W
    avg_sh = nxt >>> SH;
    red    = (mode == POOL_AVG) ? DATA_W'(avg_sh) : DATA_W'(nxt);
`ifdef POOL_RELU_EN
    if (red[DATA_W-1]) red = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      res <= '0;
    end else begin
      if (beat)  acc <= nxt;
      if (close) res <= red;
    end
  end

endmodule

// File: rtl/pool_stream_engine.sv
// Streaming max/average pooling engine: run FSM, window/output counters,
// handshakes and framing-error flag. Optional clamp: POOL_RELU_EN.
module pool_stream_engine
  import pool_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LANES     = 64,
  parameter int WIN_ELEMS = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pool_start,
  input  logic             cfg_mode,
  input  logic [CNT_W-1:0] cfg_out_count,
  output logic             pool_busy,
  output logic             pool_end,
  output logic             err_frame,
  pool_stream_engine_if.slave bus
);
  localparam int         EW      = (WIN_ELEMS > 1) ? $clog2(WIN_ELEMS) : 1;
  localparam bit         IS_POW2 = is_pow2(WIN_ELEMS);
  localparam logic [EW-1:0] LAST_E = EW'(WIN_ELEMS - 1);

  pool_state_e      state, nstate;
  pool_mode_e       mode_q;
  logic [CNT_W-1:0] cnt_q, out_cnt;
  logic [EW-1:0]    elem_cnt;
  logic             ov_q, ol_q;
  logic             start_ok, beat, close, is_last, out_acc;

  assign start_ok = (state == IDLE) && pool_start;
  assign beat     = bus.in_valid && bus.in_ready;
  assign close    = beat && (elem_cnt == LAST_E);
  assign is_last  = (out_cnt == cnt_q - 1'b1);
  assign out_acc  = ov_q && bus.out_ready;

  assign bus.out_valid = ov_q;
  assign bus.out_last  = ol_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (pool_start) nstate = (cfg_out_count == '0) ? DONE : RUN;
      RUN:   if (close && is_last) nstate = DRAIN;
      DRAIN: if (out_acc) nstate = DONE;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    pool_busy    = (state != IDLE);
    pool_end     = (state == DONE);
    bus.in_ready = (state == RUN) && (!ov_q || bus.out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= POOL_MAX;
      cnt_q     <= '0;
      out_cnt   <= '0;
      elem_cnt  <= '0;
      ov_q      <= 1'b0;
      ol_q      <= 1'b0;
      err_frame <= 1'b0;
    end else if (start_ok) begin
      // average on a non-power-of-two window degrades to max and flags it
      mode_q    <= (cfg_mode && IS_POW2) ? POOL_AVG : POOL_MAX;
      cnt_q     <= cfg_out_count;
      out_cnt   <= '0;
      elem_cnt  <= '0;
      err_frame <= cfg_mode && !IS_POW2;
    end else begin
      if (beat) begin
        elem_cnt <= close ? '0 : elem_cnt + 1'b1;
        if (bus.in_last != (elem_cnt == LAST_E)) err_frame <= 1'b1;
      end
      if (close) begin
        out_cnt <= out_cnt + 1'b1;
        ov_q    <= 1'b1;
        ol_q    <= is_last;
      end else if (out_acc) begin
        ov_q    <= 1'b0;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pool_lane_alu #(
      .DATA_W   (DATA_W),
      .WIN_ELEMS(WIN_ELEMS)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .beat (beat),
      .first(elem_cnt == '0),
      .close(close),
      .mode (mode_q),
      .din  (bus.in_data[l]),
      .res  (bus.out_data[l])
    );
  end

endmodule
